dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Memory-side responder for the pipeline's MEM-stage load/store accesses.
//  Accepts one request at a time over a valid/ready handshake and holds it for a programmable number of wait states.
//  Performs the read or write on an internal word array, then returns a response over a second valid/ready handshake.
//  Lets the pipelined datapath be tested against a memory with realistic access latency.
// PARAMETERS
//  DATA_WIDTH   32    data word width (bits)
//  ADDR_WIDTH   32    byte-address width
//  DEPTH_WORDS  1024  number of words in the array (power of 2)
//  WAIT_CYCLES  2     wait states between accept and response (0..15)
// PORTS
//  clk         in   1           rising-edge clock
//  rst         in   1           asynchronous, active-low reset
//  req_valid   in   1           request present
//  req_ready   out  1           responder can accept a request
//  req_write   in   1           1 = store, 0 = load
//  req_addr    in   ADDR_WIDTH  byte address
//  req_wdata   in   DATA_WIDTH  store data
//  resp_valid  out  1           response present
//  resp_ready  in   1           requester consumes the response
//  resp_rdata  out  DATA_WIDTH  load data (0 for stores and for errors)
//  resp_err    out  1           misaligned or out-of-range access
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0; whole array cleared to 0.
//    req_ready rises on the first clock edge after reset is released.
//  - FSM states:
//    IDLE: req_ready=1. On req_valid&req_ready, latch write/addr/wdata. Go to WAIT (WAIT_CYCLES>0) or ACCESS (WAIT_CYCLES=0).
//    WAIT: req_ready=0. Down-counter is loaded with WAIT_CYCLES-1 on accept. Go to ACCESS on the edge where the count is 0.
//    ACCESS: one cycle. Array read, or write commit, on this edge. resp_* registered. Go to RESP.
//    RESP: resp_valid=1; resp_rdata and resp_err stable until resp_valid&resp_ready. Then go to IDLE and clear resp_valid.
//  - Latency: request accepted at edge N gives resp_valid=1 after edge N+WAIT_CYCLES+1.
//    Best-case throughput is one access per WAIT_CYCLES+3 cycles. req_ready is never 1 in the same cycle as resp_valid.
//  - Address decode: word index = addr[log2(DEPTH_WORDS)+1:2].
//    resp_err=1 when addr[1:0]!=0 or addr>>2 >= DEPTH_WORDS.
//    On error there is no array write and resp_rdata=0.
//  - Store response: resp_rdata=0, resp_err per decode.
//  - Inputs are ignored outside IDLE. Latched request fields do not follow later input changes.
//  - Reset mid-operation (WAIT/ACCESS/RESP): the transaction is dropped, no write occurs if reset precedes the ACCESS edge,
//    and the responder returns to IDLE.
//  - resp_ready held high in advance is legal: the handshake completes on the first RESP cycle.
// CONFIGURATION
//  - DMEM_BYTE_STROBE_EN defined:
//    adds input req_be[DATA_WIDTH/8-1:0]. A store writes only the enabled bytes; the other bytes keep their old value.
//    A store with req_be=0 completes with no change and resp_err=0. Loads ignore req_be.
//  - DMEM_BYTE_STROBE_EN undefined: no req_be port; every store writes the full word.
// STRUCTURE
//  - Package dmem_pkg: state encoding (IDLE, WAIT, ACCESS, RESP), DATA_WIDTH/ADDR_WIDTH defaults,
//    localparam for the wait-counter width (4).
//  - Sub-module dmem_array: synchronous word array with write enable (and byte enables when DMEM_BYTE_STROBE_EN is defined),
//    asynchronous clear on rst. The FSM, counter and decode stay in dmem_responder.
// TESTING
//  1. Reset: hold rst=0 for 3 cycles. Expect req_ready=0, resp_valid=0; after release, req_ready=1 within 1 edge.
//  2. Store 0xDEADBEEF to 0x10, then load 0x10 (WAIT_CYCLES=2).
//     Expect resp_valid 3 edges after each accept, store resp_rdata=0, load resp_rdata=0xDEADBEEF, resp_err=0.
//  3. Load 0x13 (misaligned) and 0x1000 (DEPTH_WORDS=1024).
//     Expect resp_err=1, resp_rdata=0, and a follow-up load of word 0x0 unchanged.
//  4. Hold resp_ready=0 for 5 cycles in RESP. Expect resp_valid/resp_rdata stable, req_ready=0;
//     after resp_ready=1, req_ready=1 on the next cycle.
//  5. Assert rst=0 during WAIT of a store to 0x20. Expect immediate IDLE outputs; a later load of 0x20 returns 0.
//  6. With DMEM_BYTE_STROBE_EN: store 0xFFFFFFFF, then store 0x00000000 with be=4'b0101 to 0x8.
//     Expect a load of 0x8 to return 0xFF00FF00.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// default bus widths and the wait-state counter width.
package dmem_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 32;
    localparam int CNT_W          = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between a requester (master) and the
// data-memory responder (slave). The byte-strobe field req_be exists only
// when DMEM_BYTE_STROBE_EN is defined.
interface dmem_responder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
    logic [DATA_WIDTH/8-1:0] req_be;
`endif
    logic                    resp_valid;
    logic                    resp_ready;
    logic [DATA_WIDTH-1:0]   resp_rdata;
    logic                    resp_err;

    modport master (
`ifdef DMEM_BYTE_STROBE_EN
        output req_be,
`endif
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
`ifdef DMEM_BYTE_STROBE_EN
        input  req_be,
`endif
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_array.sv
// Word array behind the responder: synchronous write, combinational read,
// whole array cleared by the asynchronous reset.
// DMEM_BYTE_STROBE_EN adds per-byte write enables.
module dmem_array #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [IDX_W-1:0]        idx,
    input  logic [DATA_WIDTH-1:0]   wdata,
`ifdef DMEM_BYTE_STROBE_EN
    input  logic [DATA_WIDTH/8-1:0] be,
`endif
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    // Clear everything on reset; commit the addressed word (or its enabled bytes) on write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
        end else if (we) begin
`ifdef DMEM_BYTE_STROBE_EN
            for (int b = 0; b < DATA_WIDTH/8; b++)
                if (be[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
`else
            mem[idx] <= wdata;
`endif
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for MEM-stage loads/stores with programmable wait
// states. Optional byte strobes: DMEM_BYTE_STROBE_EN.
//
//  state     | meaning
//  ----------+---------------------------------------------------------
//  ST_IDLE   | req_ready=1, waiting for a request
//  ST_WAIT   | request latched, counting down wait states
//  ST_ACCESS | single cycle: array read / write commit, response registered
//  ST_RESP   | resp_valid=1 until the requester consumes it
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
    localparam state_t ST_AFTER_ACCEPT = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    req_ready_q, resp_valid_q, resp_err_q;
    logic [DATA_WIDTH-1:0]   resp_rdata_q;
    logic                    wr_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
`ifdef DMEM_BYTE_STROBE_EN
    logic [DATA_WIDTH/8-1:0] be_q;
`endif
    logic                    accept, addr_err, arr_we;
    logic [DATA_WIDTH-1:0]   arr_rdata;

    // req_ready is a flop, so it is only true in IDLE and is low throughout reset.
    assign accept   = bus.req_valid & req_ready_q;
    assign addr_err = (addr_q[1:0] != 2'b00) | (|addr_q[ADDR_WIDTH-1:IDX_W+2]);
    assign arr_we   = (state_q == ST_ACCESS) & wr_q & ~addr_err;

    dmem_array #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (arr_we),
        .idx   (addr_q[IDX_W+1:2]),
        .wdata (wdata_q),
`ifdef DMEM_BYTE_STROBE_EN
        .be    (be_q),
`endif
        .rdata (arr_rdata)
    );

    // Next-state and wait-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_AFTER_ACCEPT;
                    cnt_d   = WAIT_LOAD;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_d = ST_ACCESS;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP: begin
                if (resp_valid_q && bus.resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counter and registered handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= (state_d == ST_IDLE);
            resp_valid_q <= (state_d == ST_RESP);
        end
    end

    // Capture the request on accept so later input changes are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef DMEM_BYTE_STROBE_EN
            be_q    <= '0;
`endif
        end else if (accept) begin
            wr_q    <= bus.req_write;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
            be_q    <= bus.req_be;
`endif
        end
    end

    // Response payload is loaded once in ACCESS and held through RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else if (state_q == ST_ACCESS) begin
            resp_rdata_q <= (wr_q || addr_err) ? '0 : arr_rdata;
            resp_err_q   <= addr_err;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

endmodule
